// File: rtl/rr_grant_ctrl_if.sv
// rr_grant_ctrl_if
//   Bundles the push and pop signals of the round-robin grant controller.
//   Signals:
//     push     producer -> ctrl  raw per-FIFO push requests
//     push_q   ctrl -> FIFOs     qualified pushes, already masked for full FIFOs
//     out_rdy  consumer -> ctrl  consumer can take one word this cycle
//     req      ctrl -> FIFOs     pop request for the FIFO named by gnt_sel
//     gnt_sel  ctrl -> FIFOs     index of the FIFO being popped
//     count    ctrl -> observer  packed occupancy counters
//     ovf_err  ctrl -> observer  sticky "push dropped on full FIFO" flag
//   Handshake: a pop happens on every rising edge where req=1. req already
//   includes out_rdy, so req=1 means both sides agree. A push of FIFO i
//   happens on every rising edge where push_q[i]=1.
//   Modports: master = producer/consumer side (testbench); slave = controller.
interface rr_grant_ctrl_if #(
    parameter int NUM_FIFOS = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int CNTWIDTH  = 4
);
    logic [NUM_FIFOS-1:0]          push;
    logic [NUM_FIFOS-1:0]          push_q;
    logic                          out_rdy;
    logic                          req;
    logic [TAGWIDTH-1:0]           gnt_sel;
    logic [NUM_FIFOS*CNTWIDTH-1:0] count;
    logic                          ovf_err;

    modport master (
        output push, out_rdy,
        input  push_q, req, gnt_sel, count, ovf_err
    );

    modport slave (
        input  push, out_rdy,
        output push_q, req, gnt_sel, count, ovf_err
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl
//   Tracks the fill level of NUM_FIFOS downstream FIFOs, masks pushes into
//   full FIFOs, and pops one non-empty FIFO per cycle in round-robin order
//   whenever the consumer is ready.
//   Ports:
//     clk  single clock, rising edge
//     rst  synchronous active-high reset
//     bus  rr_grant_ctrl_if.slave (push, push_q, out_rdy, req, gnt_sel,
//          count, ovf_err)
//   The interface instance must use the same NUM_FIFOS, TAGWIDTH and
//   CNTWIDTH values as this module.
module rr_grant_ctrl #(
    parameter int NUM_FIFOS = 4,
    parameter int DEPTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int CNTWIDTH  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    rr_grant_ctrl_if.slave  bus
);

    localparam logic [CNTWIDTH-1:0] DEPTH_C = CNTWIDTH'(DEPTH);
    localparam logic [TAGWIDTH:0]   NUM_W   = (TAGWIDTH + 1)'(NUM_FIFOS);
    localparam logic [TAGWIDTH-1:0] LAST_C  = TAGWIDTH'(NUM_FIFOS - 1);

    logic [CNTWIDTH-1:0] cnt_q [NUM_FIFOS];
    logic [CNTWIDTH-1:0] cnt_d [NUM_FIFOS];
    logic [TAGWIDTH-1:0] ptr_q;
    logic [TAGWIDTH-1:0] ptr_d;
    logic                ovf_err_q;
    logic                ovf_err_d;

    logic [NUM_FIFOS-1:0] eligible;
    logic [NUM_FIFOS-1:0] push_ok;
    logic [TAGWIDTH-1:0]  sel;
    logic [TAGWIDTH-1:0]  idx;
    logic [TAGWIDTH:0]    sum;
    logic                 found;
    logic                 req_int;
    logic                 pop;

    always_comb begin
        eligible  = '0;
        push_ok   = '0;
        sel       = ptr_q;
        idx       = '0;
        sum       = '0;
        found     = 1'b0;
        req_int   = 1'b0;
        pop       = 1'b0;
        ptr_d     = ptr_q;
        ovf_err_d = ovf_err_q;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // Eligibility and push qualification use registered counts only, so a
        // same-cycle pop never frees space for a push and a same-cycle push
        // never makes a FIFO poppable.
        for (int i = 0; i < NUM_FIFOS; i++) begin
            eligible[i] = (cnt_q[i] != '0);
            push_ok[i]  = bus.push[i] && (cnt_q[i] < DEPTH_C);
        end

        // Scan ptr, ptr+1, ... modulo NUM_FIFOS. The sum is one bit wider so
        // the modulo works for non-power-of-two NUM_FIFOS.
        for (int k = 0; k < NUM_FIFOS; k++) begin
            sum = {1'b0, ptr_q} + (TAGWIDTH + 1)'(k);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            idx = sum[TAGWIDTH-1:0];
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        // Pops are suppressed while rst is high so the reset cycle shows an
        // idle bank.
        req_int = bus.out_rdy && found && !rst;

        if (req_int) begin
            ptr_d = (sel == LAST_C) ? '0 : sel + 1'b1;
        end

        for (int i = 0; i < NUM_FIFOS; i++) begin
            pop = req_int && (sel == TAGWIDTH'(i));
            case ({push_ok[i], pop})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        ovf_err_d = ovf_err_q | (|(bus.push & ~push_ok));
    end

    // During reset the outputs present the post-reset view: empty counters,
    // no pop, pointer at 0, and every raw push passed through.
    always_comb begin
        bus.push_q  = rst ? bus.push : push_ok;
        bus.req     = req_int;
        bus.gnt_sel = rst ? '0 : (req_int ? sel : ptr_q);
        bus.ovf_err = ovf_err_q;
        bus.count   = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                bus.count[i*CNTWIDTH +: CNTWIDTH] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q     <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q     <= ptr_d;
            ovf_err_q <= ovf_err_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int TW = 2;
    localparam int CW = 4;
    localparam int W  = 1 + TW + N;   // {req, gnt_sel, push_q}

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    rr_grant_ctrl_if #(.NUM_FIFOS(N), .TAGWIDTH(TW), .CNTWIDTH(CW)) bus ();

    rr_grant_ctrl #(.NUM_FIFOS(N), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_of(input int i);
        return int'(bus.count[i*CW +: CW]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] p, input logic r);
        bus.push    = p;
        bus.out_rdy = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 1'b0);
        step();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1010, 1'b1);
        step();
        step();
        // still in reset
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.req); end
        checks++; if (bus.gnt_sel !== 2'd0) begin errors++; $display("FAIL rst_gnt: got %0d want 0", bus.gnt_sel); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL rst_count: got %h want 0", bus.count); end
        checks++; if (bus.push_q !== 4'b1010) begin errors++; $display("FAIL rst_push_q: got %b want 1010", bus.push_q); end
        rst = 1'b0;
        drive(4'b0000, 1'b1);
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.ovf_err); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b want 0", bus.req); end
    endtask

    task automatic test_single_push();
        do_reset();
        drive(4'b0010, 1'b1);
        checks++; if (bus.push_q !== 4'b0010) begin errors++; $display("FAIL sp_push_q: got %b want 0010", bus.push_q); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL sp_req0: got %b want 0", bus.req); end
        step();
        drive(4'b0000, 1'b1);
        checks++; if (cnt_of(1) !== 1) begin errors++; $display("FAIL sp_cnt1: got %0d want 1", cnt_of(1)); end
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL sp_req1: got %b want 1", bus.req); end
        checks++; if (bus.gnt_sel !== 2'd1) begin errors++; $display("FAIL sp_gnt1: got %0d want 1", bus.gnt_sel); end
        step();
        checks++; if (cnt_of(1) !== 0) begin errors++; $display("FAIL sp_cnt1_after: got %0d want 0", cnt_of(1)); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL sp_req2: got %b want 0", bus.req); end
        checks++; if (bus.gnt_sel !== 2'd2) begin errors++; $display("FAIL sp_ptr: got %0d want 2", bus.gnt_sel); end
    endtask

    task automatic test_rr_sequence();
        logic [W-1:0] e;
        int cycles;
        do_reset();
        drive(4'b1111, 1'b0);
        step();
        step();
        drive(4'b0000, 1'b0);
        for (int i = 0; i < N; i++) begin
            checks++; if (cnt_of(i) !== 2) begin errors++; $display("FAIL rr_fill%0d: got %0d want 2", i, cnt_of(i)); end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back({1'b1, TW'(i), 4'b0000});
            end
        end
        drive(4'b0000, 1'b1);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 20) begin
            if (bus.req === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.req, bus.gnt_sel, bus.push_q} !== e) begin
                    errors++;
                    $display("FAIL rr_grant: got gnt=%0d want gnt=%0d", bus.gnt_sel, e[N +: TW]);
                end
            end
            step();
            cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL rr_timeout: %0d grants missing", exp_q.size());
            exp_q.delete();
        end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rr_idle_req: got %b want 0", bus.req); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL rr_empty: got %h want 0", bus.count); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'b0100, 1'b0);
        repeat (D) step();
        checks++; if (cnt_of(2) !== D) begin errors++; $display("FAIL ov_full: got %0d want %0d", cnt_of(2), D); end
        drive(4'b0100, 1'b1);
        checks++; if (bus.push_q !== 4'b0000) begin errors++; $display("FAIL ov_push_q: got %b want 0000", bus.push_q); end
        checks++; if (bus.req !== 1'b1 || bus.gnt_sel !== 2'd2) begin errors++; $display("FAIL ov_pop: got req=%b gnt=%0d want req=1 gnt=2", bus.req, bus.gnt_sel); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL ov_early: got %b want 0", bus.ovf_err); end
        step();
        drive(4'b0000, 1'b0);
        checks++; if (cnt_of(2) !== D - 1) begin errors++; $display("FAIL ov_cnt: got %0d want %0d", cnt_of(2), D - 1); end
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL ov_set: got %b want 1", bus.ovf_err); end
        repeat (3) step();
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL ov_sticky: got %b want 1", bus.ovf_err); end
    endtask

    task automatic test_mid_reset();
        // entered with cnt[2]=7 and ovf_err=1
        rst = 1'b1;
        drive(4'b1111, 1'b1);
        checks++; if (bus.req !== 1'b0 || bus.push_q !== 4'b1111) begin errors++; $display("FAIL mr_during: got req=%b push_q=%b want req=0 push_q=1111", bus.req, bus.push_q); end
        step();
        rst = 1'b0;
        drive(4'b0000, 1'b1);
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL mr_count: got %h want 0", bus.count); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL mr_ovf: got %b want 0", bus.ovf_err); end
        checks++; if (bus.req !== 1'b0 || bus.gnt_sel !== 2'd0) begin errors++; $display("FAIL mr_idle: got req=%b gnt=%0d want 0 0", bus.req, bus.gnt_sel); end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        drive(4'b1000, 1'b0);
        step();
        drive(4'b1000, 1'b1);
        checks++; if (bus.req !== 1'b1 || bus.gnt_sel !== 2'd3 || bus.push_q !== 4'b1000) begin errors++; $display("FAIL pp_cycle: got req=%b gnt=%0d push_q=%b want 1 3 1000", bus.req, bus.gnt_sel, bus.push_q); end
        step();
        drive(4'b0000, 1'b0);
        checks++; if (cnt_of(3) !== 1) begin errors++; $display("FAIL pp_cnt3: got %0d want 1", cnt_of(3)); end
        checks++; if (bus.gnt_sel !== 2'd0) begin errors++; $display("FAIL pp_ptr: got %0d want 0", bus.gnt_sel); end
    endtask

    task automatic test_wrap_scan();
        do_reset();
        drive(4'b0001, 1'b0);
        step();
        step();
        drive(4'b0000, 1'b1);
        step();
        drive(4'b0000, 1'b0);
        checks++; if (bus.gnt_sel !== 2'd1 || cnt_of(0) !== 1) begin errors++; $display("FAIL ws_setup: got ptr=%0d cnt0=%0d want 1 1", bus.gnt_sel, cnt_of(0)); end
        drive(4'b0000, 1'b1);
        checks++; if (bus.req !== 1'b1 || bus.gnt_sel !== 2'd0) begin errors++; $display("FAIL ws_grant: got req=%b gnt=%0d want 1 0", bus.req, bus.gnt_sel); end
        step();
        drive(4'b0000, 1'b0);
        checks++; if (bus.gnt_sel !== 2'd1 || cnt_of(0) !== 0) begin errors++; $display("FAIL ws_after: got ptr=%0d cnt0=%0d want 1 0", bus.gnt_sel, cnt_of(0)); end
    endtask

    task automatic test_random();
        int m_cnt[N];
        int m_ptr;
        logic m_ovf;
        logic [N-1:0] p;
        logic [N-1:0] e_pq;
        logic r;
        logic e_req;
        int e_gnt;
        int j;
        logic [W-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0;
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            p = N'($urandom_range(0, 15));
            r = ($urandom_range(0, 99) < ((cyc < 200) ? 20 : 75));
            drive(p, r);
            // reference model of this cycle
            for (int i = 0; i < N; i++) e_pq[i] = p[i] && (m_cnt[i] < D);
            e_req = 1'b0;
            e_gnt = m_ptr;
            if (r) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!e_req && m_cnt[j] > 0) begin
                        e_req = 1'b1;
                        e_gnt = j;
                    end
                end
            end
            exp_q.push_back({e_req, TW'(e_gnt), e_pq});
            for (int i = 0; i < N; i++) begin
                checks++; if (cnt_of(i) !== m_cnt[i]) begin errors++; $display("FAIL rnd_cnt%0d cyc%0d: got %0d want %0d", i, cyc, cnt_of(i), m_cnt[i]); end
            end
            checks++; if (bus.ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc%0d: got %b want %b", cyc, bus.ovf_err, m_ovf); end
            e = exp_q.pop_front();
            checks++;
            if ({bus.req, bus.gnt_sel, bus.push_q} !== e) begin
                errors++;
                $display("FAIL rnd_out cyc%0d: got req=%b gnt=%0d push_q=%b want req=%b gnt=%0d push_q=%b",
                         cyc, bus.req, bus.gnt_sel, bus.push_q, e[W-1], e[N +: TW], e[N-1:0]);
            end
            // advance model
            for (int i = 0; i < N; i++) begin
                if (e_pq[i]) m_cnt[i]++;
                if (e_req && e_gnt == i) m_cnt[i]--;
            end
            if (e_req) m_ptr = (e_gnt + 1) % N;
            if ((p & ~e_pq) != '0) m_ovf = 1'b1;
            step();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst         = 1'b1;
        bus.push    = '0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_single_push();
        test_rr_sequence();
        test_overflow();
        test_mid_reset();
        test_push_pop_same();
        test_wrap_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 Parameter NUM_FIFOS, default 4, number of tracked FIFOs (>=2).
REQ-002 Parameter DEPTH, default 8, capacity of each downstream FIFO in entries.
REQ-003 Parameter TAGWIDTH, default $clog2(NUM_FIFOS), width of the grant select.
REQ-004 Parameter CNTWIDTH, default $clog2(DEPTH+1), width of each occupancy counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 push  input  NUM_FIFOS  per-FIFO raw push request from producers.
REQ-008 push_q  output  NUM_FIFOS  qualified push; drives the FIFO push pins.
REQ-009 out_rdy  input  1  downstream consumer can accept one word this cycle.
REQ-010 req  output  1  pop request to the arbitrated FIFO bank.
REQ-011 gnt_sel  output  TAGWIDTH  index of the FIFO popped when req=1.
REQ-012 count  output  NUM_FIFOS*CNTWIDTH  packed occupancy counters, FIFO i at bits [(i+1)*CNTWIDTH-1:i*CNTWIDTH].
REQ-013 ovf_err  output  1  sticky flag: a raw push was dropped because the FIFO was full.

Function
REQ-014 The block SHALL keep one occupancy counter cnt[i] per FIFO, mirroring the downstream FIFO fill level.
REQ-015 push_q[i] SHALL equal push[i] & (cnt[i] < DEPTH), combinationally; no push is granted at cnt[i]==DEPTH, even if the same FIFO is popped that cycle.
REQ-016 A FIFO i SHALL be eligible when cnt[i] != 0; a push in the current cycle does not make it eligible until the next cycle.
REQ-017 req SHALL equal out_rdy & (any FIFO eligible), combinationally from registered state and out_rdy.
REQ-018 gnt_sel SHALL be the first eligible index found scanning ptr, ptr+1, ..., NUM_FIFOS-1, 0, ..., ptr-1 (modulo NUM_FIFOS).
REQ-019 When req=0, gnt_sel SHALL equal ptr.
REQ-020 Round-robin pointer ptr (TAGWIDTH bits) SHALL update to (gnt_sel+1) mod NUM_FIFOS on every cycle with req=1, and hold otherwise.
REQ-021 Wrap of ptr from NUM_FIFOS-1 SHALL go to 0, including non-power-of-two NUM_FIFOS.
REQ-022 cnt[i] next value SHALL be cnt[i] + push_q[i] - (req & gnt_sel==i).
REQ-023 For simultaneous push_q[i] and pop of i, cnt[i] SHALL hold.
REQ-024 The block SHALL never pop a FIFO with cnt[i]==0 and never push one with cnt[i]==DEPTH; counters SHALL never wrap.
REQ-025 At most one pop SHALL occur per cycle; grant latency from out_rdy rising with an eligible FIFO is 0 cycles.
REQ-026 ovf_err SHALL set on the cycle after any push[i] & ~push_q[i] and remain 1 until reset.
REQ-027 count SHALL reflect registered cnt values; changes appear the cycle after the causing push or pop.

Reset
REQ-028 While rst=1 at a clock edge, all cnt SHALL load 0, ptr SHALL load 0, and ovf_err SHALL load 0.
REQ-029 During and after the reset cycle, req=0, gnt_sel=0, count=0, and push_q=push (all counters 0 < DEPTH).
REQ-030 Reset asserted mid-operation SHALL discard all occupancy in the same edge; the downstream FIFOs SHALL be reset by the same rst.

Verification
REQ-031 Reset, then push[1]=1 for one cycle with out_rdy=1 -> cycle+1: cnt[1]=1, req=1, gnt_sel=1; cycle+2: cnt[1]=0, ptr=2, req=0.
REQ-032 cnt={2,2,2,2}, ptr=0, out_rdy=1 held with no pushes -> gnt_sel sequence 0,1,2,3,0,1,2,3, then req=0, all counts 0.
REQ-033 Fill FIFO 2 to DEPTH=8, then push[2]=1 with out_rdy=1 popping FIFO 2 -> push_q[2]=0, cnt[2]=7 next cycle, ovf_err=1 next cycle and sticky.
REQ-034 cnt[3]=1, push[3]=1 and pop of 3 in same cycle -> cnt[3] stays 1; ptr=0.
REQ-035 Only FIFO 0 eligible, ptr=1 -> gnt_sel=0 (wrap scan), ptr becomes 1 after the grant.
REQ-036 Nonzero counts and ovf_err=1, assert rst for one cycle -> next cycle count=0, ovf_err=0, req=0, gnt_sel=0.
